// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module      : imem_loader                                                  |
// | Description : Instruction-memory program loader. Receives a little-endian  |
// |               byte stream (16-bit word count, then the words), assembles   |
// |               32-bit words and writes them from word address 0 upward.     |
// |               The core is held in reset until the image is complete.       |
// | Option      : LOADER_CHECKSUM_EN - when defined, a 32-bit wrapping sum of   |
// |               all written words is checked against 4 trailing stream bytes.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk            - clock, rising edge
//   rst            - asynchronous active-high reset
//   i_start        - load start pulse (honoured in IDLE, DONE, ERROR)
//   i_byte_valid   - stream byte valid
//   i_byte_data    - stream byte
//   o_byte_ready   - loader accepts a byte this cycle
//   o_mem_we       - instruction-memory write strobe (one cycle per word)
//   o_mem_addr     - instruction-memory word address
//   o_mem_wdata    - assembled instruction word
//   o_cpu_rst      - core reset, high until the image is accepted
//   o_done         - image loaded and accepted
//   o_error        - load aborted
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd5,
`endif
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } state_t;

  // Memory capacity in words; a count equal to this is still a legal load.
  localparam logic [31:0] c_capacity = 32'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  state_t                w_after_data;

  logic [15:0]           r_len;
  logic [ADDR_WIDTH:0]   r_idx;      // one extra bit so a full load never wraps
  logic [1:0]            r_bcnt;
  logic [23:0]           r_word;     // first three bytes of the current word
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic                  w_xfer;
  logic                  w_byte_last;
  logic [15:0]           w_len_full;
  logic                  w_len_over;
  logic                  w_len_zero;
  logic [ADDR_WIDTH:0]   w_idx_inc;
  logic                  w_last_word;
  logic [31:0]           w_word_full;
  logic                  w_start_ok;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           r_csum_acc;
  logic                  w_csum_match;
`endif

  //--------------------------------------------------------------------------
  // Combinational helpers
  //--------------------------------------------------------------------------
  assign o_byte_ready = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
                        || (r_state == ST_CSUM)
`endif
                        ;

  assign w_xfer      = i_byte_valid && o_byte_ready;
  assign w_byte_last = (r_bcnt == 2'd3);
  assign w_len_full  = {i_byte_data, r_len[7:0]};
  assign w_len_over  = ({16'd0, w_len_full} > c_capacity);
  assign w_len_zero  = (w_len_full == 16'd0);
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_last_word = (32'(w_idx_inc) == {16'd0, r_len});
  // Current byte completes the word: it lands in the top byte.
  assign w_word_full = {i_byte_data, r_word};
  assign w_start_ok  = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                       (r_state == ST_ERROR);

`ifdef LOADER_CHECKSUM_EN
  assign w_after_data = ST_CSUM;
  assign w_csum_match = (w_word_full == r_csum_acc);
`else
  assign w_after_data = ST_DONE;
`endif

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) w_state_next = ST_LEN0;
      end
      ST_LEN0: begin
        if (w_xfer) w_state_next = ST_LEN1;
      end
      ST_LEN1: begin
        if (w_xfer) begin
          if (w_len_over)      w_state_next = ST_ERROR;
          else if (w_len_zero) w_state_next = w_after_data;
          else                 w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer && w_byte_last) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_state_next = w_last_word ? w_after_data : ST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_xfer && w_byte_last) w_state_next = w_csum_match ? ST_DONE : ST_ERROR;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= 16'd0;
      r_idx       <= '0;
      r_bcnt      <= 2'd0;
      r_word      <= 24'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum_acc  <= 32'd0;
`endif
    end else begin
      if (w_start_ok && i_start) begin
        r_idx      <= '0;
        r_bcnt     <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
        r_csum_acc <= 32'd0;
`endif
      end

      if (w_xfer && (r_state == ST_LEN0)) r_len[7:0]  <= i_byte_data;
      if (w_xfer && (r_state == ST_LEN1)) r_len[15:8] <= i_byte_data;

      // Data and checksum bytes share the byte counter and assembly register.
      if (w_xfer && ((r_state == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (r_state == ST_CSUM)
`endif
                    )) begin
        r_word <= {i_byte_data, r_word[23:8]};
        r_bcnt <= r_bcnt + 2'd1;
      end

      // Address and data are captured on the final byte so they are stable
      // throughout WRITE and hold afterwards.
      if (w_xfer && (r_state == ST_DATA) && w_byte_last) begin
        r_mem_addr  <= r_idx[ADDR_WIDTH-1:0];
        r_mem_wdata <= w_word_full;
`ifdef LOADER_CHECKSUM_EN
        r_csum_acc  <= r_csum_acc + w_word_full;
`endif
      end

      if (r_state == ST_WRITE) r_idx <= w_idx_inc;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign o_mem_we    = (r_state == ST_WRITE);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_done      = (r_state == ST_DONE);
  assign o_error     = (r_state == ST_ERROR);
  assign o_cpu_rst   = (r_state != ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                               |
// | Description : Directed self-checking bench for imem_loader (ADDR_WIDTH=3,  |
// |               capacity 8 words). Follows LOADER_CHECKSUM_EN if defined.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

  localparam int AW  = 3;
  localparam int CAP = 8;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte_data;
  logic          o_byte_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          o_cpu_rst;
  logic          o_done;
  logic          o_error;

  int            n_chk = 0;
  int            n_err = 0;

  logic [31:0]   img [0:15];
  logic [31:0]   wa  [0:63];
  logic [31:0]   wd  [0:63];
  int            wn = 0;
  int            base;

  imem_loader #(.ADDR_WIDTH(AW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_rst    (o_cpu_rst),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Record every write strobe; byte_ready must be low while writing.
  always @(negedge clk) begin
    if (o_mem_we === 1'b1) begin
      wa[wn % 64] = 32'(o_mem_addr);
      wd[wn % 64] = o_mem_wdata;
      wn = wn + 1;
      chk("ready_in_write", 32'(o_byte_ready), 32'd0);
    end
  end

  function automatic logic [31:0] sum_img(input int n);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i++) s = s + img[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit got;
    i_byte_valid = 1'b0;
    if (rnd && ($urandom_range(0, 1) == 1)) begin
      @(posedge clk); #1;
    end
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (o_byte_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) chk("byte_timeout", 32'(o_byte_ready), 32'd1);
    i_byte_valid = 1'b0;
  endtask

  // Full load sequence; returns #1 after the edge that enters DONE/ERROR.
  task automatic load(input int n, input int nw, input bit rnd,
                      input logic [31:0] cs, input bit poke);
    logic [7:0] b;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("start_cpu_rst", 32'(o_cpu_rst), 32'd1);
    chk("start_done_clr", 32'(o_done), 32'd0);
    b = n[7:0];  send_byte(b, rnd);
    b = n[15:8]; send_byte(b, rnd);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (poke && w == 0 && k == 1) i_start = 1'b1;
        b = img[w][8*k +: 8];
        send_byte(b, rnd);
        i_start = 1'b0;
        if (k == 3) chk("we_latency", 32'(o_mem_we), 32'd1);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (n <= CAP) begin
      for (int k = 0; k < 4; k++) begin
        b = cs[8*k +: 8];
        send_byte(b, rnd);
      end
    end
`else
    if (n > 0 && n <= CAP) begin
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0; i_byte_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready",  32'(o_byte_ready), 32'd0);
    chk("rst_we",     32'(o_mem_we),     32'd0);
    chk("rst_addr",   32'(o_mem_addr),   32'd0);
    chk("rst_wdata",  o_mem_wdata,       32'd0);
    chk("rst_done",   32'(o_done),       32'd0);
    chk("rst_error",  32'(o_error),      32'd0);
    chk("rst_cpu",    32'(o_cpu_rst),    32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-word image
    img[0] = 32'h0050_0093; img[1] = 32'h0010_8113;
    base = wn;
    load(2, 2, 1'b0, sum_img(2), 1'b0);
    chk("t2_done",  32'(o_done),    32'd1);
    chk("t2_cpu",   32'(o_cpu_rst), 32'd0);
    chk("t2_error", 32'(o_error),   32'd0);
    @(negedge clk);
    chk("t2_count", 32'(wn - base), 32'd2);
    chk("t2_a0",    wa[base],       32'd0);
    chk("t2_d0",    wd[base],       32'h0050_0093);
    chk("t2_a1",    wa[base+1],     32'd1);
    chk("t2_d1",    wd[base+1],     32'h0010_8113);
    chk("t2_addr_hold",  32'(o_mem_addr), 32'd1);
    chk("t2_wdata_hold", o_mem_wdata,     32'h0010_8113);
    chk("t2_ready_done", 32'(o_byte_ready), 32'd0);

    // Random valid gaps plus a start pulse during DATA that must be ignored
    img[0] = 32'h1122_3344; img[1] = 32'hA5A5_5A5A; img[2] = 32'h0000_0013;
    base = wn;
    load(3, 3, 1'b1, sum_img(3), 1'b1);
    chk("t3_done", 32'(o_done), 32'd1);
    @(negedge clk);
    chk("t3_count", 32'(wn - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_addr", wa[base+i], 32'(i));
      chk("t3_data", wd[base+i], img[i]);
    end

    // Oversized count aborts right after the second length byte
    base = wn;
    load(CAP + 1, 0, 1'b0, 32'd0, 1'b0);
    chk("t4_error", 32'(o_error),   32'd1);
    chk("t4_done",  32'(o_done),    32'd0);
    chk("t4_cpu",   32'(o_cpu_rst), 32'd1);
    @(negedge clk);
    chk("t4_count", 32'(wn - base), 32'd0);

    // Full-capacity load, restarted from ERROR
    for (int i = 0; i < CAP; i++) img[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    base = wn;
    load(CAP, CAP, 1'b0, sum_img(CAP), 1'b0);
    chk("t5_done",  32'(o_done),  32'd1);
    chk("t5_error", 32'(o_error), 32'd0);
    @(negedge clk);
    chk("t5_count", 32'(wn - base), 32'(CAP));
    for (int i = 0; i < CAP; i++) begin
      chk("t5_addr", wa[base+i], 32'(i));
      chk("t5_data", wd[base+i], img[i]);
    end

    // Reset in the middle of a 4-word load (after 5 data bytes)
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'h40 + 8'(k), 1'b0);
    chk("t6_pre_ready", 32'(o_byte_ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(o_byte_ready), 32'd0);
    chk("t6_rst_we",    32'(o_mem_we),     32'd0);
    chk("t6_rst_wdata", o_mem_wdata,       32'd0);
    chk("t6_rst_addr",  32'(o_mem_addr),   32'd0);
    chk("t6_rst_done",  32'(o_done),       32'd0);
    chk("t6_rst_error", 32'(o_error),      32'd0);
    chk("t6_rst_cpu",   32'(o_cpu_rst),    32'd1);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    img[0] = 32'hDEAD_BEEF;
    base = wn;
    load(1, 1, 1'b0, sum_img(1), 1'b0);
    chk("t6_done", 32'(o_done), 32'd1);
    @(negedge clk);
    chk("t6_count", 32'(wn - base), 32'd1);
    chk("t6_addr",  wa[base],       32'd0);
    chk("t6_data",  wd[base],       32'hDEAD_BEEF);

`ifdef LOADER_CHECKSUM_EN
    // Wrapping checksum: 0xFFFFFFFF + 2 = 1
    img[0] = 32'hFFFF_FFFF; img[1] = 32'h0000_0002;
    load(2, 2, 1'b0, 32'h0000_0001, 1'b0);
    chk("cs_ok_done",  32'(o_done),  32'd1);
    chk("cs_ok_error", 32'(o_error), 32'd0);
    load(2, 2, 1'b0, 32'h0000_0002, 1'b0);
    chk("cs_bad_error", 32'(o_error),   32'd1);
    chk("cs_bad_done",  32'(o_done),    32'd0);
    chk("cs_bad_cpu",   32'(o_cpu_rst), 32'd1);
`endif

    // Empty image
    base = wn;
    load(0, 0, 1'b0, 32'd0, 1'b0);
    chk("t8_done", 32'(o_done),    32'd1);
    chk("t8_cpu",  32'(o_cpu_rst), 32'd0);
    @(negedge clk);
    chk("t8_count", 32'(wn - base), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
